// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the in-order WB stage (A) always wins, and
// multi-cycle results (B) queue in a small FIFO that drains on A-idle cycles.
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_wa,
    input  logic [DATA_W-1:0] a_wd,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_wa,
    input  logic [DATA_W-1:0] b_wd,
    input  logic [ADDR_W-1:0] rd_ra1,
    input  logic [ADDR_W-1:0] rd_ra2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              stall_req,
    output logic              rf_wre,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    logic [ADDR_W-1:0] q_wa [DEPTH];
    logic [DATA_W-1:0] q_wd [DEPTH];
    logic [DEPTH-1:0]  q_vld;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [STV_W-1:0]  starve_left;
    logic [STV_W-1:0]  starve_nxt;

    logic a_win;
    logic fifo_empty;
    logic push;
    logic pop;

    // Writes to register 0 are accepted but never reach the port or the queue.
    assign a_win      = a_valid && (a_wa != '0);
    assign fifo_empty = (count == '0);
    assign pop        = !a_win && !fifo_empty;
    assign push       = b_valid && b_ready && (b_wa != '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Starvation timer counts down from the limit; terminal count means stall.
    always_comb begin
        starve_nxt = starve_left;
        if (pop || fifo_empty) begin
            starve_nxt = STV_W'(STARVE_LIM);
        end else if (a_win && (starve_left != '0)) begin
            starve_nxt = starve_left - STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_wa[wr_ptr] <= b_wa;
            q_wd[wr_ptr] <= b_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_vld       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            b_ready     <= 1'b0;
            starve_left <= STV_W'(STARVE_LIM);
            stall_req   <= 1'b0;
        end else begin
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            count       <= count_nxt;
            b_ready     <= (count_nxt != CNT_W'(DEPTH));
            starve_left <= starve_nxt;
            stall_req   <= (starve_nxt == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wre <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
        end else if (a_win) begin
            rf_wre <= 1'b1;
            rf_wa  <= a_wa;
            rf_wd  <= a_wd;
        end else if (pop) begin
            rf_wre <= 1'b1;
            rf_wa  <= q_wa[rd_ptr];
            rf_wd  <= q_wd[rd_ptr];
        end else begin
            rf_wre <= 1'b0;
        end
    end

    // Pending writes are the queued entries plus the one on the port this cycle.
    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = rf_wre && (rf_wa == rd_ra1);
        hit2 = rf_wre && (rf_wa == rd_ra2);
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_wa[i] == rd_ra1)) hit1 = 1'b1;
            if (q_vld[i] && (q_wa[i] == rd_ra2)) hit2 = 1'b1;
        end
        hazard1 = hit1 && (rd_ra1 != '0);
        hazard2 = hit2 && (rd_ra2 != '0);
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a vector table for single-cycle behaviour
// plus hand-written starvation and mid-stream reset sequences.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic [4:0]  rd_ra1;
    logic [4:0]  rd_ra2;
    logic        hazard1;
    logic        hazard2;
    logic        stall_req;
    logic        rf_wre;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .rd_ra1(rd_ra1), .rd_ra2(rd_ra2),
        .hazard1(hazard1), .hazard2(hazard2), .stall_req(stall_req),
        .rf_wre(rf_wre), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a_valid;
        logic [4:0]  a_wa;
        logic [31:0] a_wd;
        logic        b_valid;
        logic [4:0]  b_wa;
        logic [31:0] b_wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        e_wre;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_bready;
        logic        e_h1;
        logic        e_h2;
        logic        e_stall;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                                input logic bv, input logic [4:0] bw, input logic [31:0] bd,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                                input logic eb, input logic e1, input logic e2, input logic es);
        vec_t v;
        v.a_valid = av; v.a_wa = aw; v.a_wd = ad;
        v.b_valid = bv; v.b_wa = bw; v.b_wd = bd;
        v.ra1 = r1; v.ra2 = r2;
        v.e_wre = ew; v.e_wa = ea; v.e_wd = ed;
        v.e_bready = eb; v.e_h1 = e1; v.e_h2 = e2; v.e_stall = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        if (stall_req === 1'b1) chk("protocol a_valid during stall_req", {31'd0, a_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_wa = '0; a_wd = '0;
        b_valid = 1'b0; b_wa = '0; b_wd = '0;
    endtask

    initial begin
        // a_valid a_wa a_wd  b_valid b_wa b_wd  ra1 ra2 | wre wa wd  b_ready h1 h2 stall
        vecs[0]  = mk(1, 5,  32'h1234, 0, 0,  0,         5,  0,  1, 5,  32'h1234, 1, 1, 0, 0);
        vecs[1]  = mk(1, 0,  32'hFFFF, 0, 0,  0,         5,  0,  0, 5,  32'h1234, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0,  0,        1, 9,  32'hDEAD,  9,  5,  0, 5,  32'h1234, 1, 1, 0, 0);
        vecs[3]  = mk(0, 0,  0,        0, 0,  0,         9,  0,  1, 9,  32'hDEAD, 1, 1, 0, 0);
        vecs[4]  = mk(0, 0,  0,        0, 0,  0,         9,  0,  0, 9,  32'hDEAD, 1, 0, 0, 0);
        vecs[5]  = mk(1, 7,  32'h77,   1, 3,  32'h33,    3,  4,  1, 7,  32'h77,   1, 1, 0, 0);
        vecs[6]  = mk(1, 8,  32'h88,   1, 4,  32'h44,    3,  4,  1, 8,  32'h88,   0, 1, 1, 0);
        vecs[7]  = mk(1, 10, 32'hAA,   1, 6,  32'h66,    6,  4,  1, 10, 32'hAA,   0, 0, 1, 0);
        vecs[8]  = mk(0, 0,  0,        0, 0,  0,         3,  4,  1, 3,  32'h33,   1, 1, 1, 0);
        vecs[9]  = mk(0, 0,  0,        0, 0,  0,         3,  4,  1, 4,  32'h44,   1, 0, 1, 0);
        vecs[10] = mk(0, 0,  0,        0, 0,  0,         3,  4,  0, 4,  32'h44,   1, 0, 0, 0);
        vecs[11] = mk(0, 0,  0,        1, 0,  32'h55,    0,  5,  0, 4,  32'h44,   1, 0, 0, 0);
        vecs[12] = mk(0, 0,  0,        0, 0,  0,         0,  4,  0, 4,  32'h44,   1, 0, 0, 0);
        vecs[13] = mk(0, 0,  0,        1, 12, 32'hC1,    12, 0,  0, 4,  32'h44,   1, 1, 0, 0);
        vecs[14] = mk(0, 0,  0,        1, 13, 32'hC2,    13, 12, 1, 12, 32'hC1,   1, 1, 1, 0);
        vecs[15] = mk(0, 0,  0,        0, 0,  0,         13, 12, 1, 13, 32'hC2,   1, 1, 0, 0);
        vecs[16] = mk(0, 0,  0,        0, 0,  0,         13, 12, 0, 13, 32'hC2,   1, 0, 0, 0);

        rst = 1'b1;
        idle_inputs();
        rd_ra1 = '0; rd_ra2 = '0;
        #12;
        chk("reset rf_wre", {31'd0, rf_wre}, 32'd0);
        chk("reset b_ready", {31'd0, b_ready}, 32'd0);
        chk("reset stall_req", {31'd0, stall_req}, 32'd0);
        chk("reset rf_wa", {27'd0, rf_wa}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("post-reset b_ready", {31'd0, b_ready}, 32'd1);
        chk("post-reset rf_wre", {31'd0, rf_wre}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            a_valid = vecs[i].a_valid; a_wa = vecs[i].a_wa; a_wd = vecs[i].a_wd;
            b_valid = vecs[i].b_valid; b_wa = vecs[i].b_wa; b_wd = vecs[i].b_wd;
            rd_ra1 = vecs[i].ra1; rd_ra2 = vecs[i].ra2;
            step();
            chk($sformatf("v%0d rf_wre", i), {31'd0, rf_wre}, {31'd0, vecs[i].e_wre});
            chk($sformatf("v%0d rf_wa", i), {27'd0, rf_wa}, {27'd0, vecs[i].e_wa});
            chk($sformatf("v%0d rf_wd", i), rf_wd, vecs[i].e_wd);
            chk($sformatf("v%0d b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].e_bready});
            chk($sformatf("v%0d hazard1", i), {31'd0, hazard1}, {31'd0, vecs[i].e_h1});
            chk($sformatf("v%0d hazard2", i), {31'd0, hazard2}, {31'd0, vecs[i].e_h2});
            chk($sformatf("v%0d stall_req", i), {31'd0, stall_req}, {31'd0, vecs[i].e_stall});
        end

        // Starvation: one queued B entry while A wins every cycle.
        a_valid = 1'b1; a_wa = 5'd1; a_wd = 32'h1;
        b_valid = 1'b1; b_wa = 5'd20; b_wd = 32'hBB;
        rd_ra1 = 5'd20; rd_ra2 = 5'd0;
        step();
        chk("starve push stall_req", {31'd0, stall_req}, 32'd0);
        chk("starve push hazard1", {31'd0, hazard1}, 32'd1);
        b_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("starve win%0d stall_req", i), {31'd0, stall_req}, (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("starve win%0d rf_wa", i), {27'd0, rf_wa}, 32'd1);
        end
        a_valid = 1'b0;
        step();
        chk("starve drain stall_req", {31'd0, stall_req}, 32'd0);
        chk("starve drain rf_wre", {31'd0, rf_wre}, 32'd1);
        chk("starve drain rf_wa", {27'd0, rf_wa}, 32'd20);
        chk("starve drain rf_wd", rf_wd, 32'hBB);
        step();
        chk("starve idle rf_wre", {31'd0, rf_wre}, 32'd0);

        // Reset mid-stream with two queued B writes.
        a_valid = 1'b1; a_wa = 5'd2; a_wd = 32'h2;
        b_valid = 1'b1; b_wa = 5'd21; b_wd = 32'hF1;
        rd_ra1 = 5'd21; rd_ra2 = 5'd22;
        step();
        b_wa = 5'd22; b_wd = 32'hF2;
        step();
        chk("rst-mid queued b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst-mid queued hazard1", {31'd0, hazard1}, 32'd1);
        chk("rst-mid queued hazard2", {31'd0, hazard2}, 32'd1);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst-mid rf_wre", {31'd0, rf_wre}, 32'd0);
        chk("rst-mid rf_wa", {27'd0, rf_wa}, 32'd0);
        chk("rst-mid b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst-mid hazard1", {31'd0, hazard1}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("rst-mid release b_ready", {31'd0, b_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst-mid drain%0d rf_wre", i), {31'd0, rf_wre}, 32'd0);
            chk($sformatf("rst-mid drain%0d hazard1", i), {31'd0, hazard1}, 32'd0);
            chk($sformatf("rst-mid drain%0d hazard2", i), {31'd0, hazard2}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
